// File: rtl/spi_eeprom_emu_p.sv
// SPI mode-0 serial-EEPROM slave emulator for the NDS save path: decodes WREN/WRDI/RDSR/WRSR/
// READ/FAST_READ/WRITE into single-byte read/write pulses served by the save-RAM arbiter on mclk.
`timescale 1ns/1ps
module spi_eeprom_emu_p #(
  parameter int ADDR_BYTES = 2,
  parameter int MEM_BITS   = 16,
  parameter int PAGE_BITS  = 5,
  localparam int AW        = 8 * ADDR_BYTES
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          spi_clk,
  input  logic          spi_mosi,
  input  logic          spi_cs,
  inout  wire           spi_miso,
  output logic          mem_begin_rd,
  output logic          mem_begin_wr,
  input  logic          mem_finish,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data_wr,
  input  logic [7:0]    mem_data_rd,
  output logic [7:0]    status_out,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DUMMY, S_DATA_RD, S_DATA_WR, S_RDSR, S_WRSR, S_DONE
  } state_t;
  typedef enum logic [1:0] {OP_READ, OP_FAST, OP_WRITE} op_t;

  localparam logic [AW-1:0] PAGE_MASK = AW'((1 << PAGE_BITS) - 1);

  // Memory port: mem_begin_rd/mem_begin_wr are 1-cycle requests with mem_addr held until the
  // next request; the arbiter answers a read with a 1-cycle mem_finish carrying mem_data_rd.
  // There is no back-pressure: a finish arriving after the next MISO byte boundary is lost.

  function automatic logic [AW-1:0] mask_addr(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    for (int i = 0; i < AW; i++) m[i] = (i < MEM_BITS) ? a[i] : 1'b0;
    return m;
  endfunction

  function automatic logic [AW-1:0] page_inc(input logic [AW-1:0] a);
    return (a & ~PAGE_MASK) | ((a + AW'(1)) & PAGE_MASK);
  endfunction

  function automatic logic is_prot(input logic [AW-1:0] a, input logic [1:0] bp);
    case (bp)
      2'b00:   return 1'b0;
      2'b01:   return a[MEM_BITS-1] & a[MEM_BITS-2];
      2'b10:   return a[MEM_BITS-1];
      default: return 1'b1;
    endcase
  endfunction

  logic [2:0]    sclk_q, sclk_d;
  logic [1:0]    mosi_q, mosi_d;
  logic [1:0]    cs_q, cs_d;
  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    addr_cnt_q, addr_cnt_d;
  logic [6:0]    rx_sr_q, rx_sr_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    miso_sr_q, miso_sr_d;
  logic [7:0]    miso_nxt_q, miso_nxt_d;
  logic [AW-1:0] addr_asm_q, addr_asm_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    data_wr_q, data_wr_d;
  logic          begin_rd_q, begin_rd_d;
  logic          begin_wr_q, begin_wr_d;
  logic          wel_q, wel_d;
  logic          wel_clr_q, wel_clr_d;
  logic [1:0]    bp_q, bp_d;
  logic          srwd_q, srwd_d;

  logic       sclk_rise, sclk_fall, cs_s, mosi_s;
  logic [7:0] status;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_s      = cs_q[1];
  assign mosi_s    = mosi_q[1];
  assign status    = {srwd_q, 3'b000, bp_q, wel_q, 1'b0};

  always_comb begin
    sclk_d     = {sclk_q[1:0], spi_clk};
    mosi_d     = {mosi_q[0], spi_mosi};
    cs_d       = {cs_q[0], spi_cs};
    state_d    = state_q;
    op_d       = op_q;
    bit_cnt_d  = bit_cnt_q;
    addr_cnt_d = addr_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_byte_d  = rx_byte_q;
    strobe_d   = 1'b0;
    miso_sr_d  = miso_sr_q;
    miso_nxt_d = miso_nxt_q;
    addr_asm_d = addr_asm_q;
    wr_addr_d  = wr_addr_q;
    mem_addr_d = mem_addr_q;
    data_wr_d  = data_wr_q;
    begin_rd_d = 1'b0;
    begin_wr_d = 1'b0;
    wel_d      = wel_q;
    wel_clr_d  = wel_clr_q;
    bp_d       = bp_q;
    srwd_d     = srwd_q;

    if (cs_s) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 3'd0;
      addr_cnt_d = 2'd0;
      rx_sr_d    = 7'd0;
      miso_sr_d  = 8'hFF;
      miso_nxt_d = 8'hFF;
      if (wel_clr_q) wel_d = 1'b0;
      wel_clr_d  = 1'b0;
    end else begin
      if (sclk_rise) begin
        rx_sr_d   = {rx_sr_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          strobe_d  = 1'b1;
          rx_byte_d = {rx_sr_q, mosi_s};
        end
      end
      // The falling edge after the 8th rising edge hands over the staged byte (FF if none).
      if (sclk_fall) begin
        if (bit_cnt_q == 3'd0) begin
          miso_sr_d  = miso_nxt_q;
          miso_nxt_d = 8'hFF;
        end else begin
          miso_sr_d = {miso_sr_q[6:0], 1'b1};
        end
      end
      if (mem_finish && state_q == S_DATA_RD) miso_nxt_d = mem_data_rd;

      if (strobe_q) begin
        case (state_q)
          S_IDLE: begin
            addr_cnt_d = 2'd0;
            case (rx_byte_q)
              8'h06: begin wel_d = 1'b1; state_d = S_DONE; end
              8'h04: begin wel_d = 1'b0; state_d = S_DONE; end
              8'h05: begin miso_nxt_d = status; state_d = S_RDSR; end
              8'h01: state_d = S_WRSR;
              8'h03: begin op_d = OP_READ;  state_d = S_ADDR; end
              8'h0B: begin op_d = OP_FAST;  state_d = S_ADDR; end
              8'h02: begin op_d = OP_WRITE; state_d = S_ADDR; end
              default: state_d = S_DONE;
            endcase
          end
          S_ADDR: begin
            addr_asm_d = mask_addr((addr_asm_q << 8) | AW'(rx_byte_q));
            if (addr_cnt_q == 2'(ADDR_BYTES - 1)) begin
              case (op_q)
                OP_READ: begin
                  state_d    = S_DATA_RD;
                  begin_rd_d = 1'b1;
                  mem_addr_d = addr_asm_d;
                end
                OP_FAST: state_d = S_DUMMY;
                default: begin
                  state_d   = S_DATA_WR;
                  wr_addr_d = addr_asm_d;
                end
              endcase
            end else begin
              addr_cnt_d = addr_cnt_q + 2'd1;
            end
          end
          S_DUMMY: begin
            state_d    = S_DATA_RD;
            begin_rd_d = 1'b1;
            mem_addr_d = addr_asm_q;
          end
          S_DATA_RD: begin
            begin_rd_d = 1'b1;
            mem_addr_d = mask_addr(mem_addr_q + AW'(1));
          end
          S_DATA_WR: begin
            wel_clr_d = 1'b1;
            wr_addr_d = page_inc(wr_addr_q);
            if (wel_q && !is_prot(wr_addr_q, bp_q)) begin
              begin_wr_d = 1'b1;
              mem_addr_d = wr_addr_q;
              data_wr_d  = rx_byte_q;
            end
          end
          S_RDSR: miso_nxt_d = status;
          S_WRSR: begin
            if (wel_q) begin
              srwd_d = rx_byte_q[7];
              bp_d   = rx_byte_q[3:2];
            end
            wel_clr_d = 1'b1;
            state_d   = S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sclk_q     <= 3'd0;
      mosi_q     <= 2'd0;
      cs_q       <= 2'b11;
      state_q    <= S_IDLE;
      op_q       <= OP_READ;
      bit_cnt_q  <= 3'd0;
      addr_cnt_q <= 2'd0;
      rx_sr_q    <= 7'd0;
      rx_byte_q  <= 8'd0;
      strobe_q   <= 1'b0;
      miso_sr_q  <= 8'hFF;
      miso_nxt_q <= 8'hFF;
      addr_asm_q <= '0;
      wr_addr_q  <= '0;
      mem_addr_q <= '0;
      data_wr_q  <= 8'd0;
      begin_rd_q <= 1'b0;
      begin_wr_q <= 1'b0;
      wel_q      <= 1'b0;
      wel_clr_q  <= 1'b0;
      bp_q       <= 2'd0;
      srwd_q     <= 1'b0;
    end else begin
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      state_q    <= state_d;
      op_q       <= op_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_byte_q  <= rx_byte_d;
      strobe_q   <= strobe_d;
      miso_sr_q  <= miso_sr_d;
      miso_nxt_q <= miso_nxt_d;
      addr_asm_q <= addr_asm_d;
      wr_addr_q  <= wr_addr_d;
      mem_addr_q <= mem_addr_d;
      data_wr_q  <= data_wr_d;
      begin_rd_q <= begin_rd_d;
      begin_wr_q <= begin_wr_d;
      wel_q      <= wel_d;
      wel_clr_q  <= wel_clr_d;
      bp_q       <= bp_d;
      srwd_q     <= srwd_d;
    end
  end

  assign spi_miso     = spi_cs ? 1'bz : miso_sr_q[7];
  assign mem_begin_rd = begin_rd_q;
  assign mem_begin_wr = begin_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_wr  = data_wr_q;
  assign status_out   = status;
  assign dbg_state    = state_q;

endmodule
